// File: rtl/dircc_avalon_st_terminal_pkg.sv
// Shared types and constants for the DiRCC Avalon-ST terminal.
//   state_t       : framing FSM state (IDLE, IN_PACKET)
//   ERR_*         : 4-bit error codes reported in the status register
//   CSR_*         : CSR word addresses and control bit positions
package dircc_avalon_st_terminal_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } state_t;

  localparam logic [3:0] ERR_NONE   = 4'd0;
  localparam logic [3:0] ERR_NO_SOP = 4'd1;  // data beat outside a packet
  localparam logic [3:0] ERR_NO_EOP = 4'd2;  // sop arrived before previous eop
  localparam logic [3:0] ERR_EMPTY  = 4'd3;  // non-zero empty on a non-eop beat

  localparam logic [1:0] CSR_STATUS     = 2'd0;
  localparam logic [1:0] CSR_PKT_COUNT  = 2'd1;
  localparam logic [1:0] CSR_BEAT_COUNT = 2'd2;
  localparam logic [1:0] CSR_CHECKSUM   = 2'd3;

  localparam int CSR_CLR_ERR_BIT = 0;
  localparam int CSR_CLR_CNT_BIT = 1;

endpackage

// File: rtl/dircc_avalon_st_terminal_csr.sv
// Avalon-MM CSR slave for the terminal: decodes clear writes and returns
// registered read data one cycle after csr_read.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   csr_address/read/write/writedata : Avalon-MM slave request
//   csr_readdata          : registered read data, holds between reads
//   error, error_code, in_packet, packet_count, beat_count, last_checksum :
//                           live status sources from the framing logic
//   clr_err, clr_cnt      : single-cycle clear strobes back to the framing logic
module dircc_avalon_st_terminal_csr
  import dircc_avalon_st_terminal_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  input  logic        error,
  input  logic [3:0]  error_code,
  input  logic        in_packet,
  input  logic [31:0] packet_count,
  input  logic [31:0] beat_count,
  input  logic [31:0] last_checksum,
  output logic        clr_err,
  output logic        clr_cnt
);

  logic [31:0] read_mux;
  logic        status_write;
  logic        unused_writedata;

  // Only the status word is writable; writes elsewhere are dropped.
  assign status_write     = csr_write && (csr_address == CSR_STATUS);
  assign clr_err          = status_write && csr_writedata[CSR_CLR_ERR_BIT];
  assign clr_cnt          = status_write && csr_writedata[CSR_CLR_CNT_BIT];
  assign unused_writedata = ^csr_writedata[31:2];

  always_comb begin
    read_mux = '0;
    case (csr_address)
      CSR_STATUS:     read_mux = {24'b0, error_code, 2'b0, in_packet, error};
      CSR_PKT_COUNT:  read_mux = packet_count;
      CSR_BEAT_COUNT: read_mux = beat_count;
      CSR_CHECKSUM:   read_mux = last_checksum;
      default:        read_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      csr_readdata <= read_mux;
    end
  end

endmodule

// File: rtl/dircc_avalon_st_terminal.sv
// DiRCC Avalon-ST packet terminal: sinks every beat, checks sop/eop framing,
// keeps packet/beat counters and the XOR checksum of the last packet, and
// flags framing errors through a sticky error bit and a CSR status word.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   s1_*             : Avalon-ST sink (valid/ready/data/sop/eop/empty)
//   error            : sticky framing-error flag
//   csr_*            : Avalon-MM CSR slave (see dircc_avalon_st_terminal_csr)
//
// Handshake: a beat transfers on a rising edge where s1_valid && s1_ready.
// s1_ready is low while in reset and for the first edge after release, then
// stays high; there is no backpressure.
module dircc_avalon_st_terminal
  import dircc_avalon_st_terminal_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s1_valid,
  output logic                   s1_ready,
  input  logic [DATA_WIDTH-1:0]  s1_data,
  input  logic                   s1_startofpacket,
  input  logic                   s1_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] s1_empty,
  output logic                   error,
  input  logic [1:0]             csr_address,
  input  logic                   csr_read,
  output logic [31:0]            csr_readdata,
  input  logic                   csr_write,
  input  logic [31:0]            csr_writedata
);

  state_t                state, state_nxt;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] running_q, running_nxt;
  logic [DATA_WIDTH-1:0] last_q, last_nxt;
  logic [31:0]           packet_count_q, beat_count_q;
  logic                  error_q;
  logic [3:0]            error_code_q;
  logic                  accept;
  logic                  beat_inc, pkt_inc;
  logic [3:0]            frame_code, new_code;
  logic                  clr_err, clr_cnt;
  logic [31:0]           checksum_csr;

  assign s1_ready = ready_q;
  assign error    = error_q;
  assign accept   = s1_valid && ready_q;

  // Framing FSM: next state, checksum update and counter increments.
  always_comb begin
    state_nxt   = state;
    running_nxt = running_q;
    last_nxt    = last_q;
    beat_inc    = 1'b0;
    pkt_inc     = 1'b0;
    frame_code  = ERR_NONE;
    if (accept) begin
      case (state)
        IDLE: begin
          if (s1_startofpacket) begin
            beat_inc = 1'b1;
            if (s1_endofpacket) begin
              last_nxt = s1_data;
              pkt_inc  = 1'b1;
            end else begin
              running_nxt = s1_data;
              state_nxt   = IN_PACKET;
            end
          end else begin
            frame_code = ERR_NO_SOP;
          end
        end
        IN_PACKET: begin
          beat_inc = 1'b1;
          if (s1_startofpacket) begin
            // Abandon the open packet; this beat starts a fresh one.
            frame_code = ERR_NO_EOP;
            if (s1_endofpacket) begin
              last_nxt  = s1_data;
              pkt_inc   = 1'b1;
              state_nxt = IDLE;
            end else begin
              running_nxt = s1_data;
            end
          end else if (s1_endofpacket) begin
            last_nxt  = running_q ^ s1_data;
            pkt_inc   = 1'b1;
            state_nxt = IDLE;
          end else begin
            running_nxt = running_q ^ s1_data;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A beat can violate framing and empty rules at once; the framing code is
  // reported in that case.
  always_comb begin
    new_code = frame_code;
    if (frame_code == ERR_NONE && accept && !s1_endofpacket &&
        (s1_empty != '0)) begin
      new_code = ERR_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      ready_q        <= 1'b0;
      running_q      <= '0;
      last_q         <= '0;
      packet_count_q <= '0;
      beat_count_q   <= '0;
      error_q        <= 1'b0;
      error_code_q   <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      ready_q   <= 1'b1;
      running_q <= running_nxt;
      last_q    <= last_nxt;

      // A clear coinciding with a beat leaves just that beat's contribution.
      if (clr_cnt) begin
        packet_count_q <= {31'b0, pkt_inc};
        beat_count_q   <= {31'b0, beat_inc};
      end else begin
        packet_count_q <= packet_count_q + {31'b0, pkt_inc};
        beat_count_q   <= beat_count_q + {31'b0, beat_inc};
      end

      // New error beats a simultaneous clear; the code only latches when no
      // earlier error is still held.
      if (new_code != ERR_NONE) begin
        error_q <= 1'b1;
        if (!error_q || clr_err) begin
          error_code_q <= new_code;
        end
      end else if (clr_err) begin
        error_q      <= 1'b0;
        error_code_q <= ERR_NONE;
      end
    end
  end

  generate
    if (DATA_WIDTH >= 32) begin : g_cs_trunc
      assign checksum_csr = last_q[31:0];
    end else begin : g_cs_ext
      assign checksum_csr = {{(32 - DATA_WIDTH){1'b0}}, last_q};
    end
  endgenerate

  dircc_avalon_st_terminal_csr u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .error         (error_q),
    .error_code    (error_code_q),
    .in_packet     (state == IN_PACKET),
    .packet_count  (packet_count_q),
    .beat_count    (beat_count_q),
    .last_checksum (checksum_csr),
    .clr_err       (clr_err),
    .clr_cnt       (clr_cnt)
  );

endmodule

// File: tb/tb_dircc_avalon_st_terminal.sv
module tb_dircc_avalon_st_terminal;

  localparam int DW = 32;
  localparam int EW = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          s1_valid = 1'b0;
  logic          s1_ready;
  logic [DW-1:0] s1_data = '0;
  logic          s1_startofpacket = 1'b0;
  logic          s1_endofpacket = 1'b0;
  logic [EW-1:0] s1_empty = '0;
  logic          error;
  logic [1:0]    csr_address = '0;
  logic          csr_read = 1'b0;
  logic [31:0]   csr_readdata;
  logic          csr_write = 1'b0;
  logic [31:0]   csr_writedata = '0;

  dircc_avalon_st_terminal #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s1_valid         (s1_valid),
    .s1_ready         (s1_ready),
    .s1_data          (s1_data),
    .s1_startofpacket (s1_startofpacket),
    .s1_endofpacket   (s1_endofpacket),
    .s1_empty         (s1_empty),
    .error            (error),
    .csr_address      (csr_address),
    .csr_read         (csr_read),
    .csr_readdata     (csr_readdata),
    .csr_write        (csr_write),
    .csr_writedata    (csr_writedata)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Packet contents are collected in a queue; the checksum is folded at eop.
  logic [31:0] pkt_q[$];
  bit          m_in = 0;
  bit          m_err = 0;
  logic [3:0]  m_code = 0;
  logic [31:0] m_pc = 0, m_bc = 0, m_last = 0;

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_code, 2'b0, m_in, m_err};
      2'd1:    return m_pc;
      2'd2:    return m_bc;
      default: return m_last;
    endcase
  endfunction

  function automatic logic [31:0] xor_all();
    logic [31:0] x = '0;
    foreach (pkt_q[i]) x ^= pkt_q[i];
    return x;
  endfunction

  task automatic model_step(input bit v, input bit sop, input bit eop,
                            input logic [31:0] d, input logic [1:0] e,
                            input bit wr, input logic [1:0] a, input logic [31:0] wd);
    int          code = 0;
    logic [31:0] binc = 0, pinc = 0;
    if (v) begin
      if (sop) begin
        if (m_in) code = 2;
        pkt_q.delete();
        pkt_q.push_back(d);
        binc = 1;
        if (eop) begin m_last = xor_all(); pinc = 1; m_in = 0; end
        else m_in = 1;
      end else if (!m_in) begin
        code = 1;
      end else begin
        pkt_q.push_back(d);
        binc = 1;
        if (eop) begin m_last = xor_all(); pinc = 1; m_in = 0; end
      end
      if (!eop && e != 0 && code == 0) code = 3;
    end
    if (wr && a == 2'd0) begin
      if (wd[0]) begin m_err = 0; m_code = 0; end
      if (wd[1]) begin m_pc = 0; m_bc = 0; end
    end
    m_pc += pinc;
    m_bc += binc;
    if (code != 0) begin
      if (!m_err) m_code = 4'(code);
      m_err = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit v, input bit sop, input bit eop, input logic [31:0] d,
                     input logic [1:0] e, input bit rd, input logic [1:0] a,
                     input bit wr, input logic [31:0] wd);
    s1_valid = v; s1_startofpacket = sop; s1_endofpacket = eop;
    s1_data = d; s1_empty = e;
    csr_address = a; csr_read = rd; csr_write = wr; csr_writedata = wd;
    if (rd) exp_q.push_back(m_reg(a));
    @(posedge clk);
    model_step(v, sop, eop, d, e, wr, a, wd);
    #1;
    s1_valid = 1'b0; csr_read = 1'b0; csr_write = 1'b0;
    check("ready", {31'b0, s1_ready}, 32'd1);
    check("error", {31'b0, error}, {31'b0, m_err});
    if (rd) check($sformatf("csr%0d", a), csr_readdata, exp_q.pop_front());
  endtask

  task automatic beat(input bit sop, input bit eop, input logic [31:0] d, input logic [1:0] e);
    cyc(1, sop, eop, d, e, 0, 2'd0, 0, 32'd0);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] wd);
    cyc(0, 0, 0, 32'd0, 2'd0, 0, a, 1, wd);
  endtask

  // Read via the model and also against a constant taken from the test plan.
  task automatic csr_rd_k(input logic [1:0] a, input logic [31:0] k, input string tag);
    cyc(0, 0, 0, 32'd0, 2'd0, 1, a, 0, 32'd0);
    check(tag, csr_readdata, k);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, s1_ready}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_rdata", csr_readdata, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rel", {31'b0, s1_ready}, 32'd1);
    for (int a = 0; a < 4; a++) csr_rd_k(2'(a), 32'd0, $sformatf("rst_csr%0d", a));

    // three-beat packet
    beat(1, 0, 32'h12345678, 0);
    beat(0, 0, 32'h9ABCDEF0, 0);
    beat(0, 1, 32'h0F0F0F0F, 0);
    check("pkt3_error", {31'b0, error}, 32'd0);
    csr_rd_k(2'd1, 32'd1, "pkt3_pc");
    csr_rd_k(2'd2, 32'd3, "pkt3_bc");
    csr_rd_k(2'd3, 32'h87878787, "pkt3_cs");

    // data outside a packet
    beat(0, 0, 32'hDEADBEEF, 0);
    check("nosop_error", {31'b0, error}, 32'd1);
    csr_rd_k(2'd0, 32'h11, "nosop_status");
    csr_rd_k(2'd1, 32'd1, "nosop_pc");
    csr_rd_k(2'd2, 32'd3, "nosop_bc");
    csr_wr(2'd0, 32'h1);
    check("clr_error", {31'b0, error}, 32'd0);
    csr_rd_k(2'd0, 32'h0, "clr_status");

    // missing eop
    csr_wr(2'd0, 32'h3);
    beat(1, 0, 32'h1, 0);
    beat(1, 0, 32'h2, 0);
    beat(0, 1, 32'h4, 0);
    csr_rd_k(2'd0, 32'h21, "noeop_status");
    csr_rd_k(2'd1, 32'd1, "noeop_pc");
    csr_rd_k(2'd2, 32'd3, "noeop_bc");
    csr_rd_k(2'd3, 32'h6, "noeop_cs");

    // non-zero empty on a non-eop beat
    csr_wr(2'd0, 32'h1);
    beat(1, 0, 32'h55, 2);
    check("empty_error", {31'b0, error}, 32'd1);
    csr_rd_k(2'd0, 32'h33, "empty_status");
    beat(0, 1, 32'h66, 1);

    // single-beat packet
    csr_wr(2'd0, 32'h3);
    beat(1, 1, 32'hA5A5A5A5, 0);
    check("single_error", {31'b0, error}, 32'd0);
    csr_rd_k(2'd1, 32'd1, "single_pc");
    csr_rd_k(2'd3, 32'hA5A5A5A5, "single_cs");

    // counter clear coinciding with a beat, then an ignored write
    cyc(1, 1, 1, 32'h77, 0, 0, 2'd0, 1, 32'h2);
    csr_rd_k(2'd1, 32'd1, "clrbeat_pc");
    csr_rd_k(2'd2, 32'd1, "clrbeat_bc");
    csr_wr(2'd1, 32'hFFFFFFFF);
    csr_rd_k(2'd1, 32'd1, "ignored_wr");

    // error coinciding with a clear: the new error is kept
    cyc(1, 0, 0, 32'h1, 0, 0, 2'd0, 1, 32'h1);
    csr_rd_k(2'd0, 32'h11, "err_vs_clr");

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit          v   = ($urandom_range(0, 1) == 1);
      bit          sop = ($urandom_range(0, 3) == 0);
      bit          eop = ($urandom_range(0, 3) == 0);
      logic [1:0]  e   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bit          rd  = ($urandom_range(0, 2) == 0);
      bit          wr  = ($urandom_range(0, 15) == 0);
      logic [1:0]  a   = 2'($urandom_range(0, 3));
      logic [31:0] wd  = 32'($urandom_range(0, 3));
      cyc(v, sop, eop, $urandom, e, rd, a, wr, wd);
    end

    // reset mid-packet returns to IDLE with everything cleared
    beat(1, 0, 32'hCAFE, 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    pkt_q.delete();
    m_in = 0; m_err = 0; m_code = 0; m_pc = 0; m_bc = 0; m_last = 0;
    csr_rd_k(2'd0, 32'h0, "midrst_status");
    csr_rd_k(2'd2, 32'd0, "midrst_bc");
    beat(0, 1, 32'h1, 0);
    check("midrst_idle", {31'b0, error}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dircc_avalon_st_terminal.md
Name: dircc_avalon_st_terminal

Overview:
Avalon-ST packet sink ("terminal") that terminates a DiRCC packet stream. It consumes every beat, checks packet framing, and raises a sticky error flag on protocol violations. It keeps packet and beat counters plus an XOR checksum of the last packet. A small Avalon-MM CSR slave exposes status and counters to a host.

Parameters:
DATA_WIDTH, 32, width of the ST data bus (multiple of 8).
EMPTY_WIDTH, 2, width of the empty field, equal to log2(DATA_WIDTH/8).

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock, synchronous, active-low
s1_valid  in  1  ST sink beat valid
s1_ready  out  1  ST sink ready
s1_data  in  DATA_WIDTH  ST beat data
s1_startofpacket  in  1  first beat of a packet
s1_endofpacket  in  1  last beat of a packet
s1_empty  in  EMPTY_WIDTH  unused bytes in an eop beat
error  out  1  sticky framing-error flag
csr_address  in  2  CSR word address
csr_read  in  1  CSR read strobe
csr_readdata  out  32  CSR read data
csr_write  in  1  CSR write strobe
csr_writedata  in  32  CSR write data

Behaviour:
- Reset (reset_n=0 sampled at posedge clk):
  - s1_ready=0, error=0, csr_readdata=0.
  - All counters, checksum and error_code = 0.
  - State = IDLE.
- s1_ready is 1 in every cycle after reset is released. There is no backpressure, so a beat is accepted when s1_valid=1.
- States:
  - IDLE:
    - sop=1, eop=0: go to IN_PACKET; running checksum = data; beat_count+1.
    - sop=1, eop=1 (single-beat packet): stay in IDLE; last_checksum = data; packet_count+1; beat_count+1.
    - sop=0: error code 1 (data outside packet); beat dropped, no counters change.
  - IN_PACKET:
    - sop=0, eop=0: running checksum ^= data; beat_count+1.
    - eop=1: last_checksum = running ^ data; packet_count+1; beat_count+1; go to IDLE.
    - sop=1: error code 2 (missing eop). The old packet is abandoned and not counted. The beat starts a new packet (same handling as an IDLE sop beat).
- Any accepted beat with eop=0 and empty≠0 gives error code 3. The beat is otherwise processed normally.
- Error handling:
  - error is set on the cycle after the offending beat and stays set until cleared.
  - error_code (4 bits) keeps the first error code recorded since the last clear.
- Counters are 32 bits and wrap from 0xFFFFFFFF to 0 without flagging.
- CSR:
  - Read latency is 1 cycle: csr_readdata is registered on the cycle after csr_read=1 and holds its value otherwise.
  - Map:
    - 0 = status {24'b0, error_code[3:0], 2'b0, in_packet, error}
    - 1 = packet_count
    - 2 = beat_count
    - 3 = last_checksum
  - Write to address 0 with bit0=1 clears error and error_code. Write with bit1=1 clears both counters.
  - Writes to addresses 1–3 are ignored.
- Simultaneous events:
  - A new error in the same cycle as a clear: the new error wins.
  - A counter clear in the same cycle as a beat: counter = value contributed by that beat (0 or 1).
- Reset mid-packet discards the partial packet and returns to IDLE.

Decomposition:
- Package dircc_avalon_st_terminal_pkg holds:
  - state enum {IDLE, IN_PACKET}
  - error-code constants ERR_NONE=0, ERR_NO_SOP=1, ERR_NO_EOP=2, ERR_EMPTY=3
  - CSR address constants
- One sub-module, dircc_avalon_st_terminal_csr, holds the register file and readdata mux. Framing FSM and counters live in the top.

Test Plan:
- Hold reset_n=0 for 10 clks, then release → s1_ready=0 during reset, 1 one clk later; error=0; all CSRs read 0.
- Send 3-beat packet (sop,eop)=(1,0),(0,0),(0,1), data 0x12345678, 0x9ABCDEF0, 0x0F0F0F0F, empty=0:
  - error stays 0
  - packet_count=1, beat_count=3
  - last_checksum=0x87878787
- Send beat sop=0 while IDLE, data 0xDEADBEEF → error=1, status=0x00000011, counters unchanged; write 0x1 to addr 0 → error=0, status=0x0.
- Send sop beat, then a second sop beat before eop, then eop → error_code=2, packet_count=1, beat_count=3.
- Send non-eop beat with empty=2 → error_code=3, error=1.
- Send single-beat packet sop=1, eop=1, data 0xA5A5A5A5 → packet_count=1, last_checksum=0xA5A5A5A5, no error.
